shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_shift_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// Round-robin arbiter that lets four requesters share one serial shifter.
// Requesters post operands; one is granted, the shifter is issued, its result
// (or a timeout) is returned with a one-cycle done pulse to that requester.
module shift_arbiter (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [3:0]  req_i,
    input  logic [3:0]  rl_i,
    input  logic [3:0]  al_i,
    input  logic [15:0] amt_i,
    input  logic [63:0] data_i,
    output logic [3:0]  gnt_o,
    output logic [3:0]  done_o,
    output logic        err_o,
    output logic [15:0] result_o,
    output logic        busy_o,
    output logic        sh_write_pulse_o,
    output logic        sh_right_left_o,
    output logic        sh_arith_logic_o,
    output logic [3:0]  sh_shift_amount_o,
    output logic [15:0] sh_data_o,
    input  logic        sh_ready_pulse_i,
    input  logic [15:0] sh_data_i
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Counter value in the last WAIT cycle before giving up. The counter is
    // zero in the first WAIT cycle and done_o is registered out of DONE, so a
    // timed-out request reports done_o/err_o 18 cycles after WAIT entry.
    localparam logic [4:0] TimeoutLast = 5'd16;

    state_e      r_state;
    state_e      w_state_d;

    logic [1:0]  r_last_grant;
    logic [1:0]  r_idx;
    logic [3:0]  r_gnt;
    logic [3:0]  r_done;
    logic        r_err;
    logic        r_timed_out;
    logic        r_rl;
    logic        r_al;
    logic [3:0]  r_amt;
    logic [15:0] r_data;
    logic [15:0] r_stage;
    logic [15:0] r_result;
    logic [4:0]  r_cnt;

    logic [1:0]  w_start;
    logic [3:0]  w_rot;
    logic [1:0]  w_off;
    logic [1:0]  w_winner;
    logic        w_any;
    logic        w_grant;
    logic [3:0]  w_sel_amt;
    logic [15:0] w_sel_data;
    logic        w_sel_rl;
    logic        w_sel_al;
    logic        w_ready_hit;
    logic        w_timeout;
    logic        w_drive_sh;

    // Round-robin pick: rotate requests so the search starts after the last
    // winner, take the lowest set bit, then rotate the offset back.
    always_comb begin
        w_start  = r_last_grant + 2'd1;
        w_rot    = 4'({req_i, req_i} >> w_start);
        w_any    = |req_i;
        w_off    = 2'd0;
        if (w_rot[0]) begin
            w_off = 2'd0;
        end else if (w_rot[1]) begin
            w_off = 2'd1;
        end else if (w_rot[2]) begin
            w_off = 2'd2;
        end else begin
            w_off = 2'd3;
        end
        w_winner   = w_start + w_off;
        w_sel_amt  = amt_i[{w_winner, 2'b00} +: 4];
        w_sel_data = data_i[{w_winner, 4'b0000} +: 16];
        w_sel_rl   = rl_i[w_winner];
        w_sel_al   = al_i[w_winner];
    end

    // Event decodes; a ready pulse outside WAIT is simply not looked at.
    always_comb begin
        w_grant     = (r_state == StIdle) && w_any;
        w_ready_hit = (r_state == StWait) && sh_ready_pulse_i;
        w_timeout   = (r_state == StWait) && !sh_ready_pulse_i && (r_cnt == TimeoutLast);
        w_drive_sh  = (r_state == StIssue) || (r_state == StWait);
    end

    // Next-state logic.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_any) begin
                    // A zero amount never gets a ready pulse, so skip the shifter.
                    w_state_d = (w_sel_amt != 4'd0) ? StIssue : StDone;
                end
            end
            StIssue: begin
                w_state_d = StWait;
            end
            StWait: begin
                if (w_ready_hit || w_timeout) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Latch the winner's request fields on the grant edge.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_last_grant <= 2'd3;
            r_idx        <= 2'd0;
            r_rl         <= 1'b0;
            r_al         <= 1'b0;
            r_amt        <= 4'd0;
            r_data       <= 16'h0000;
        end else if (w_grant) begin
            r_last_grant <= w_winner;
            r_idx        <= w_winner;
            r_rl         <= w_sel_rl;
            r_al         <= w_sel_al;
            r_amt        <= w_sel_amt;
            r_data       <= w_sel_data;
        end
    end

    // Result staging and WAIT-cycle counter; the stage holds the pending
    // result until DONE publishes it.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_stage     <= 16'h0000;
            r_timed_out <= 1'b0;
            r_cnt       <= 5'd0;
        end else begin
            if (w_grant) begin
                r_stage     <= w_sel_data;
                r_timed_out <= 1'b0;
            end
            if (r_state == StIssue) begin
                r_cnt <= 5'd0;
            end
            if (w_ready_hit) begin
                r_stage <= sh_data_i;
            end else if (w_timeout) begin
                r_stage     <= 16'h0000;
                r_timed_out <= 1'b1;
            end else if (r_state == StWait) begin
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    // Registered grant, completion and error pulses plus the published result.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_gnt    <= 4'd0;
            r_done   <= 4'd0;
            r_err    <= 1'b0;
            r_result <= 16'h0000;
        end else begin
            r_gnt  <= w_grant ? (4'b0001 << w_winner) : 4'd0;
            r_done <= (r_state == StDone) ? (4'b0001 << r_idx) : 4'd0;
            r_err  <= (r_state == StDone) && r_timed_out;
            if (r_state == StDone) begin
                r_result <= r_stage;
            end
        end
    end

    // Outputs; shifter controls stay steady from ISSUE through WAIT.
    always_comb begin
        gnt_o             = r_gnt;
        done_o            = r_done;
        err_o             = r_err;
        result_o          = r_result;
        busy_o            = (r_state != StIdle);
        sh_write_pulse_o  = (r_state == StIssue);
        sh_right_left_o   = w_drive_sh ? r_rl : 1'b0;
        sh_arith_logic_o  = w_drive_sh ? r_al : 1'b0;
        sh_shift_amount_o = w_drive_sh ? r_amt : 4'd0;
        sh_data_o         = w_drive_sh ? r_data : 16'h0000;
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: a timeline model of the arbiter, a behavioural
// serial shifter, a per-cycle compare process and directed literal checks.
module tb_shift_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic [3:0]  req_i = 4'd0;
    logic [3:0]  rl_i = 4'd0;
    logic [3:0]  al_i = 4'd0;
    logic [15:0] amt_i = 16'd0;
    logic [63:0] data_i = 64'd0;
    logic [3:0]  gnt_o;
    logic [3:0]  done_o;
    logic        err_o;
    logic [15:0] result_o;
    logic        busy_o;
    logic        sh_write_pulse_o;
    logic        sh_right_left_o;
    logic        sh_arith_logic_o;
    logic [3:0]  sh_shift_amount_o;
    logic [15:0] sh_data_o;
    logic        sh_ready_pulse_i = 1'b0;
    logic [15:0] sh_data_i = 16'hDEAD;

    shift_arbiter dut (
        .clk_i             (clk_i),
        .reset_ni          (reset_ni),
        .req_i             (req_i),
        .rl_i              (rl_i),
        .al_i              (al_i),
        .amt_i             (amt_i),
        .data_i            (data_i),
        .gnt_o             (gnt_o),
        .done_o            (done_o),
        .err_o             (err_o),
        .result_o          (result_o),
        .busy_o            (busy_o),
        .sh_write_pulse_o  (sh_write_pulse_o),
        .sh_right_left_o   (sh_right_left_o),
        .sh_arith_logic_o  (sh_arith_logic_o),
        .sh_shift_amount_o (sh_shift_amount_o),
        .sh_data_o         (sh_data_o),
        .sh_ready_pulse_i  (sh_ready_pulse_i),
        .sh_data_i         (sh_data_i)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_bad = 0;
    bit mute = 1'b0;   // shifter never answers
    bit stray = 1'b0;  // one unsolicited ready pulse

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] shift_ref(input logic [15:0] d, input logic [3:0] a,
                                              input logic r, input logic ar);
        if (!r) return d << a;
        if (ar) return 16'($signed(d) >>> a);
        return d >> a;
    endfunction

    // Timeline model: each grant books cycles g..d; done lands at d.
    int          cyc = 0;
    int          m_g = -100;
    int          m_d = -100;
    int          m_w = 0;
    int          m_last = 3;
    bit          m_errp = 1'b0;
    logic [15:0] m_pend = 16'h0;
    logic [15:0] m_res = 16'h0;
    logic [3:0]  m_amt = 4'd0;
    logic [15:0] m_data = 16'h0;
    logic        m_rl = 1'b0;
    logic        m_al = 1'b0;

    initial begin
        forever begin
            @(posedge clk_i);
            if (!reset_ni) begin
                m_g = -100;
                m_d = -100;
                m_last = 3;
                m_res = 16'h0;
                m_errp = 1'b0;
                cyc++;
            end else begin
                int prev;
                prev = cyc;
                cyc++;
                if (!(prev >= m_g && prev <= m_d - 1) && req_i != 4'd0) begin
                    int w;
                    w = 0;
                    for (int k = 4; k >= 1; k--) begin
                        if (req_i[(m_last + k) % 4]) w = (m_last + k) % 4;
                    end
                    m_w = w;
                    m_last = w;
                    m_g = cyc;
                    m_amt = amt_i[4*w +: 4];
                    m_data = data_i[16*w +: 16];
                    m_rl = rl_i[w];
                    m_al = al_i[w];
                    if (m_amt == 4'd0) begin
                        m_d = m_g + 1;
                        m_pend = m_data;
                        m_errp = 1'b0;
                    end else if (mute) begin
                        m_d = m_g + 19;
                        m_pend = 16'h0;
                        m_errp = 1'b1;
                    end else begin
                        m_d = m_g + int'(m_amt) + 2;
                        m_pend = shift_ref(m_data, m_amt, m_rl, m_al);
                        m_errp = 1'b0;
                    end
                end
                if (cyc == m_d) m_res = m_pend;
            end
        end
    end

    // Serial shifter: answers amt cycles after the load strobe cycle.
    initial begin
        bit          s_act;
        int          s_rem;
        logic [15:0] s_val;
        s_act = 1'b0;
        s_rem = 0;
        s_val = 16'h0;
        forever begin
            bit fire;
            @(negedge clk_i);
            fire = 1'b0;
            if (!reset_ni) begin
                s_act = 1'b0;
            end else begin
                if (s_act) begin
                    s_rem--;
                    if (s_rem == 0) begin
                        fire = 1'b1;
                        s_act = 1'b0;
                    end
                end
                if (sh_write_pulse_o && !mute) begin
                    s_act = 1'b1;
                    s_rem = int'(sh_shift_amount_o);
                    s_val = shift_ref(sh_data_o, sh_shift_amount_o, sh_right_left_o,
                                      sh_arith_logic_o);
                end
            end
            if (fire) begin
                sh_ready_pulse_i = 1'b1;
                sh_data_i = s_val;
            end else if (stray) begin
                sh_ready_pulse_i = 1'b1;
                sh_data_i = 16'hBEEF;
                stray = 1'b0;
            end else begin
                sh_ready_pulse_i = 1'b0;
                sh_data_i = 16'hDEAD;
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!reset_ni) begin
                check("rst_gnt", gnt_o, 0);
                check("rst_done", done_o, 0);
                check("rst_err", err_o, 0);
                check("rst_busy", busy_o, 0);
                check("rst_write", sh_write_pulse_o, 0);
                check("rst_result", result_o, 0);
                check("rst_sh_data", sh_data_o, 0);
                check("rst_sh_amt", sh_shift_amount_o, 0);
                check("rst_sh_ctl", {sh_right_left_o, sh_arith_logic_o}, 0);
            end else begin
                check("cyc_gnt", gnt_o, (cyc == m_g) ? (32'd1 << m_w) : 32'd0);
                check("cyc_done", done_o, (cyc == m_d) ? (32'd1 << m_w) : 32'd0);
                check("cyc_err", err_o, (cyc == m_d) && m_errp);
                check("cyc_busy", busy_o, (cyc >= m_g) && (cyc <= m_d - 1));
                check("cyc_write", sh_write_pulse_o, (cyc == m_g) && (m_amt != 4'd0));
                check("cyc_result", result_o, m_res);
                if (m_amt != 4'd0 && cyc >= m_g && cyc <= m_d - 2) begin
                    check("cyc_sh_data", sh_data_o, m_data);
                    check("cyc_sh_amt", sh_shift_amount_o, m_amt);
                    check("cyc_sh_ctl", {sh_right_left_o, sh_arith_logic_o}, {m_rl, m_al});
                end
            end
        end
    end

    task automatic run_op(input string nm, input int r, input logic [15:0] d,
                          input logic [3:0] a, input logic rl, input logic al,
                          input int lat, input logic [15:0] res, input logic er,
                          input int glitch);
        bit ok;
        int k;
        int writes;
        data_i[16*r +: 16] = d;
        amt_i[4*r +: 4] = a;
        rl_i[r] = rl;
        al_i[r] = al;
        req_i[r] = 1'b1;
        if (!mute) check({nm, "_ref"}, shift_ref(d, a, rl, al), res);
        ok = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk_i);
            if (gnt_o != 4'd0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check({nm, "_gnt_seen"}, 0, 1);
            req_i[r] = 1'b0;
            return;
        end
        check({nm, "_gnt"}, gnt_o, 32'd1 << r);
        req_i[r] = 1'b0;
        writes = int'(sh_write_pulse_o);
        k = 0;
        ok = 1'b0;
        while (k < 40) begin
            @(negedge clk_i);
            k++;
            if (glitch >= 0 && k == 3) req_i[glitch] = 1'b1;
            if (glitch >= 0 && k == 6) req_i[glitch] = 1'b0;
            writes += int'(sh_write_pulse_o);
            if (done_o != 4'd0) begin
                ok = 1'b1;
                break;
            end
        end
        check({nm, "_latency"}, k, lat);
        check({nm, "_done"}, done_o, 32'd1 << r);
        check({nm, "_result"}, result_o, res);
        check({nm, "_err"}, err_o, er);
        check({nm, "_writes"}, writes, (a != 4'd0) ? 1 : 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no $finish, expected end of run");
        $fatal(1);
    end

    initial begin
        bit ok;
        int dones;
        logic [3:0] exp_gnt [5];
        exp_gnt[0] = 4'b0001;
        exp_gnt[1] = 4'b0010;
        exp_gnt[2] = 4'b0100;
        exp_gnt[3] = 4'b1000;
        exp_gnt[4] = 4'b0001;

        repeat (3) @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);

        run_op("single", 0, 16'h8001, 4'd1, 1'b1, 1'b0, 3, 16'h4000, 1'b0, -1);
        run_op("arith", 2, 16'h8000, 4'd15, 1'b1, 1'b1, 17, 16'hFFFF, 1'b0, 3);
        run_op("zero", 1, 16'h1234, 4'd0, 1'b1, 1'b0, 1, 16'h1234, 1'b0, -1);
        run_op("left", 3, 16'h00F3, 4'd4, 1'b0, 1'b0, 6, 16'h0F30, 1'b0, -1);
        run_op("logic_r", 0, 16'hF0F0, 4'd4, 1'b1, 1'b0, 6, 16'h0F0F, 1'b0, -1);
        run_op("arith_pos", 1, 16'h7F00, 4'd8, 1'b1, 1'b1, 10, 16'h007F, 1'b0, -1);
        mute = 1'b1;
        run_op("timeout", 2, 16'h1111, 4'd5, 1'b1, 1'b0, 19, 16'h0000, 1'b1, 3);
        @(negedge clk_i);
        check("timeout_idle", busy_o, 0);
        mute = 1'b0;

        // Unsolicited ready while idle must not complete anything.
        stray = 1'b1;
        dones = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (done_o != 4'd0) dones++;
        end
        check("stray_idle_dones", dones, 0);

        // Fairness: all four held high from reset.
        reset_ni = 1'b0;
        data_i = {16'h0F00, 16'h8000, 16'h1234, 16'h0003};
        amt_i = {4'd3, 4'd2, 4'd0, 4'd1};
        rl_i = 4'b0110;
        al_i = 4'b0100;
        req_i = 4'b1111;
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dones = 0;
            ok = 1'b0;
            for (int t = 0; t < 40; t++) begin
                @(negedge clk_i);
                if (done_o != 4'd0) dones++;
                if (gnt_o != 4'd0) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) check("fair_gnt_seen", 0, 1);
            check("fair_order", gnt_o, exp_gnt[i]);
            if (i > 0) check("fair_done_between", dones, 1);
        end
        req_i = 4'd0;
        repeat (8) @(negedge clk_i);

        // Reset in the middle of a 15-bit shift.
        data_i[15:0] = 16'h8000;
        amt_i[3:0] = 4'd15;
        rl_i[0] = 1'b1;
        al_i[0] = 1'b1;
        req_i[0] = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk_i);
            if (gnt_o != 4'd0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("rstmid_gnt_seen", 0, 1);
        req_i[0] = 1'b0;
        repeat (6) @(negedge clk_i);
        check("rstmid_busy_before", busy_o, 1);
        @(posedge clk_i);
        #1 reset_ni = 1'b0;
        #1;
        check("rstmid_outputs", {gnt_o, done_o, err_o, busy_o, sh_write_pulse_o}, 0);
        check("rstmid_result", result_o, 0);
        check("rstmid_sh", {sh_data_o, sh_shift_amount_o, sh_right_left_o, sh_arith_logic_o}, 0);
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);
        stray = 1'b1;
        dones = 0;
        repeat (25) begin
            @(negedge clk_i);
            if (done_o != 4'd0) dones++;
        end
        check("rstmid_no_done", dones, 0);

        repeat (2) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
